// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
// Releases NUM_DOMAINS reset domains one at a time after the chip reset
// deasserts. Assertion of rst is asynchronous and reaches every output at
// once. Release goes through a synchronizer, a hold period, and then a
// per-domain ready handshake that gives up after TIMEOUT_CYCLES and flags it.
// A software request restarts the sequence from the hold period.
module reset_release_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int CUR_W         = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_reset_req,
    input  logic [NUM_DOMAINS-1:0] domain_ready_i,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   done_o,
    output logic [NUM_DOMAINS-1:0] err_o,
    output logic [CUR_W-1:0]       cur_domain_o
);

    // One counter serves the hold, wait and gap phases, so it is sized for
    // the longest of the three.
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_ALL > 0) ? $clog2(MAX_ALL + 1) : 1;

    // Counter value at which each phase finishes on the current edge.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CUR_W-1:0] LAST_DOM  = CUR_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_HOLD = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [CUR_W-1:0]       next_idx;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_DOMAINS-1:0] err_q, err_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    logic                   ready_cur;

    // Saturating increment: the counter parks at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    assign rst_sync  = sync_q[SYNC_STAGES-1];
    assign next_idx  = cur_q + CUR_W'(1);
    assign ready_cur = domain_ready_i[cur_q];

    // Deassertion synchronizer: set asynchronously by rst, shifts in zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next output values; a software request overrides
    // whatever the current phase would otherwise do on this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        dom_rst_d = dom_rst_q;
        err_d     = err_q;
        done_d    = done_q;

        if (state_q != ST_SYNC && sw_reset_req) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            cur_d     = '0;
            dom_rst_d = '1;
            err_d     = '0;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    // Leave on the edge where rst_sync itself falls, so the
                    // hold period starts counting at edge SYNC_STAGES.
                    if (!rst_sync || !sync_q[SYNC_STAGES-2]) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q >= HOLD_LAST) begin
                        dom_rst_d[0] = 1'b0;
                        cur_d        = '0;
                        cnt_d        = '0;
                        state_d      = ST_WAIT;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_WAIT: begin
                    // Ready is only looked at from the edge after release,
                    // which is the first edge spent in this state.
                    if (ready_cur || cnt_q >= TO_LAST) begin
                        if (!ready_cur) begin
                            err_d[cur_q] = 1'b1;
                        end
                        cnt_d = '0;
                        if (cur_q == LAST_DOM) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_GAP: begin
                    // With GAP_CYCLES=0 this releases on the very next edge.
                    if (cnt_q >= GAP_LAST) begin
                        dom_rst_d[next_idx] = 1'b0;
                        cur_d               = next_idx;
                        cnt_d               = '0;
                        state_d             = ST_WAIT;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // Registered outputs and the shared phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cur_q     <= '0;
            dom_rst_q <= '1;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            dom_rst_q <= dom_rst_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign domain_rst_o = dom_rst_q;
    assign err_o        = err_q;
    assign done_o       = done_q;
    assign cur_domain_o = cur_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer with default parameters: a table of
// expected outputs at chosen edges, hand-built corner sequences, and random
// ready/software-request traffic checked against an edge-timeline model.
module tb_reset_release_sequencer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int TO   = 16;
    localparam int INF  = 1 << 30;

    logic         clk;
    logic         rst;
    logic         sw;
    logic [N-1:0] ready;
    logic [N-1:0] domain_rst_o;
    logic         done_o;
    logic [N-1:0] err_o;
    logic [1:0]   cur_domain_o;
    logic [10:0]  outs;

    int checks;
    int errors;
    int edge_n;

    localparam logic [10:0] RST_V = {4'b1111, 1'b0, 4'b0000, 2'd0};

    reset_release_sequencer #(
        .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_reset_req(sw),
        .domain_ready_i(ready),
        .domain_rst_o(domain_rst_o),
        .done_o(done_o),
        .err_o(err_o),
        .cur_domain_o(cur_domain_o)
    );

    assign outs = {domain_rst_o, done_o, err_o, cur_domain_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-timeline reference: each domain's release edge and acknowledge
    // edge are derived from the timing rules; outputs follow from them.
    int          m_e;
    int          m_hold;
    int          m_rel[N];
    int          m_ack[N];
    logic [N-1:0] m_err;

    function automatic logic [10:0] ev(input logic [3:0] r, input logic d,
                                       input logic [3:0] e, input logic [1:0] c);
        return {r, d, e, c};
    endfunction

    function automatic void model_reset();
        m_e    = 0;
        m_hold = SYNC;
        m_err  = '0;
        for (int i = 0; i < N; i++) begin
            m_rel[i] = INF;
            m_ack[i] = INF;
        end
    endfunction

    function automatic void model_edge(input logic s, input logic [N-1:0] rdy);
        m_e++;
        if (s && m_e > SYNC) begin
            m_hold = m_e;
            m_err  = '0;
            for (int i = 0; i < N; i++) begin
                m_rel[i] = INF;
                m_ack[i] = INF;
            end
            return;
        end
        if (m_rel[0] == INF && m_e == m_hold + HOLD) m_rel[0] = m_e;
        for (int i = 0; i < N; i++) begin
            if (m_rel[i] != INF && m_ack[i] == INF && m_e > m_rel[i]) begin
                if (rdy[i]) begin
                    m_ack[i] = m_e;
                end else if (m_e == m_rel[i] + TO) begin
                    m_ack[i] = m_e;
                    m_err[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N - 1; i++) begin
            if (m_ack[i] != INF && m_rel[i+1] == INF && m_e == m_ack[i] + GAP + 1)
                m_rel[i+1] = m_e;
        end
    endfunction

    function automatic logic [10:0] model_out();
        logic [3:0] r;
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < N; i++) begin
            r[i] = (m_rel[i] > m_e);
            if (m_rel[i] <= m_e) c = 2'(i);
        end
        return {r, (m_ack[N-1] <= m_e), m_err, c};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got rst=%b done=%b err=%b cur=%0d, expected rst=%b done=%b err=%b cur=%0d",
                     name, edge_n, act[10:7], act[6], act[5:2], act[1:0],
                     exp[10:7], exp[6], exp[5:2], exp[1:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int e);
        while (edge_n < e) tick();
    endtask

    // Assert rst, confirm reset values without waiting for a clock, then
    // release it just after an edge so that the next edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        sw  = 1'b0;
        #1;
        chk("reset_values", outs, RST_V);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
        model_reset();
    endtask

    typedef struct {
        int          run;
        int          edge_no;
        logic [3:0]  rdy;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        rst    = 1'b1;
        sw     = 1'b0;
        ready  = '0;
        model_reset();

        // Run 0: every domain acknowledges immediately.
        vecs.push_back('{0,  1, 4'b1111, ev(4'b1111, 0, 4'b0000, 0)});
        vecs.push_back('{0,  9, 4'b1111, ev(4'b1111, 0, 4'b0000, 0)});
        vecs.push_back('{0, 10, 4'b1111, ev(4'b1110, 0, 4'b0000, 0)});
        vecs.push_back('{0, 13, 4'b1111, ev(4'b1110, 0, 4'b0000, 0)});
        vecs.push_back('{0, 14, 4'b1111, ev(4'b1100, 0, 4'b0000, 1)});
        vecs.push_back('{0, 17, 4'b1111, ev(4'b1100, 0, 4'b0000, 1)});
        vecs.push_back('{0, 18, 4'b1111, ev(4'b1000, 0, 4'b0000, 2)});
        vecs.push_back('{0, 22, 4'b1111, ev(4'b0000, 0, 4'b0000, 3)});
        vecs.push_back('{0, 23, 4'b1111, ev(4'b0000, 1, 4'b0000, 3)});
        // Run 1: domain 1 never acknowledges and times out.
        vecs.push_back('{1, 14, 4'b1101, ev(4'b1100, 0, 4'b0000, 1)});
        vecs.push_back('{1, 29, 4'b1101, ev(4'b1100, 0, 4'b0000, 1)});
        vecs.push_back('{1, 30, 4'b1101, ev(4'b1100, 0, 4'b0010, 1)});
        vecs.push_back('{1, 32, 4'b1101, ev(4'b1100, 0, 4'b0010, 1)});
        vecs.push_back('{1, 33, 4'b1101, ev(4'b1000, 0, 4'b0010, 2)});
        vecs.push_back('{1, 36, 4'b1101, ev(4'b1000, 0, 4'b0010, 2)});
        vecs.push_back('{1, 37, 4'b1101, ev(4'b0000, 0, 4'b0010, 3)});
        vecs.push_back('{1, 38, 4'b1101, ev(4'b0000, 1, 4'b0010, 3)});

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].run != vecs[i-1].run) begin
                ready = vecs[i].rdy;
                do_reset();
            end
            tick_to(vecs[i].edge_no);
            chk($sformatf("table_run%0d", vecs[i].run), outs, vecs[i].exp);
        end

        // Software pulse after done clears the sticky timeout flag.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("sw_pulse_clears", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick_to(46);
        chk("sw_pulse_hold", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick();
        chk("sw_pulse_release", outs, ev(4'b1110, 0, 4'b0000, 0));

        // Request held for five edges (48..52) pushes release to 52+8.
        sw = 1'b1;
        repeat (5) tick();
        sw = 1'b0;
        tick_to(59);
        chk("sw_held_hold", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick();
        chk("sw_held_release", outs, ev(4'b1110, 0, 4'b0000, 0));

        // Asynchronous rst mid-sequence, then a clean replay of run 0 timing.
        ready = 4'b1111;
        do_reset();
        tick_to(15);
        chk("pre_async", outs, ev(4'b1100, 0, 4'b0000, 1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_immediate", outs, RST_V);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        edge_n = 0;
        tick_to(9);
        chk("replay_e9", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick_to(10);
        chk("replay_e10", outs, ev(4'b1110, 0, 4'b0000, 0));
        tick_to(14);
        chk("replay_e14", outs, ev(4'b1100, 0, 4'b0000, 1));
        tick_to(18);
        chk("replay_e18", outs, ev(4'b1000, 0, 4'b0000, 2));
        tick_to(22);
        chk("replay_e22", outs, ev(4'b0000, 0, 4'b0000, 3));
        tick_to(23);
        chk("replay_e23", outs, ev(4'b0000, 1, 4'b0000, 3));

        // Software request on the same edge as the domain 1 timeout.
        ready = 4'b1101;
        do_reset();
        tick_to(29);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("sw_vs_timeout", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick_to(37);
        chk("sw_vs_timeout_hold", outs, ev(4'b1111, 0, 4'b0000, 0));
        tick_to(38);
        chk("sw_vs_timeout_rel", outs, ev(4'b1110, 0, 4'b0000, 0));

        // Early ready on domain 0 is ignored; the later ready drives timing.
        ready = 4'b1111;
        do_reset();
        tick_to(10);
        ready[0] = 1'b0;
        tick_to(12);
        chk("late_ready_wait", outs, ev(4'b1110, 0, 4'b0000, 0));
        ready[0] = 1'b1;
        tick_to(15);
        chk("late_ready_gap", outs, ev(4'b1110, 0, 4'b0000, 0));
        tick_to(16);
        chk("late_ready_rel", outs, ev(4'b1100, 0, 4'b0000, 1));

        // Random ready and request traffic against the timeline model.
        for (int ep = 0; ep < 14; ep++) begin
            int pct[N];
            int ncyc;
            logic [N-1:0] rdy;
            do_reset();
            for (int d = 0; d < N; d++) begin
                case ($urandom_range(0, 3))
                    0:       pct[d] = 0;
                    1:       pct[d] = 8;
                    2:       pct[d] = 40;
                    default: pct[d] = 95;
                endcase
            end
            ncyc = int'($urandom_range(40, 130));
            for (int c = 0; c < ncyc; c++) begin
                sw = ($urandom_range(0, 99) < 3);
                for (int d = 0; d < N; d++) rdy[d] = ($urandom_range(0, 99) < pct[d]);
                ready = rdy;
                tick();
                model_edge(sw, rdy);
                chk("random", outs, model_out());
            end
            sw = 1'b0;
            #3;
            rst = 1'b1;
            #1;
            chk("random_async_rst", outs, RST_V);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Sequences release of up to NUM_DOMAINS downstream reset domains from one asynchronous, active-high chip reset. Reset assertion is asynchronous to every domain. Deassertion goes through a local synchronizer, a hold period, and then domain-by-domain release gated by a per-domain ready handshake with timeout. It sits between the top-level reset pin and the asynchronously reset registers of each subsystem, and it also accepts a software re-reset request.

## Interface
- NUM_DOMAINS, 4, number of reset domains (1..16)
- SYNC_STAGES, 2, synchronizer flops on rst deassertion (>=2)
- HOLD_CYCLES, 8, cycles all domains stay in reset after synchronized release (>=1)
- GAP_CYCLES, 2, idle cycles between ready of domain i and release of domain i+1 (>=0)
- TIMEOUT_CYCLES, 16, max cycles waiting for ready before forced advance (>=1)
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high, clock clk
- sw_reset_req  in  1  synchronous request to re-reset all domains
- domain_ready_i  in  NUM_DOMAINS  per-domain "out of reset" acknowledge, synchronous to clk
- domain_rst_o  out  NUM_DOMAINS  per-domain reset, active-high, registered
- done_o  out  1  all domains released and acknowledged (or timed out)
- err_o  out  NUM_DOMAINS  sticky per-domain timeout flags
- cur_domain_o  out  clog2(NUM_DOMAINS) (min 1)  index of domain currently being released

## Operation
- Reset values (rst high, applied immediately, no clock needed): domain_rst_o all ones, done_o 0, err_o 0, cur_domain_o 0, FSM SYNC, counters 0, synchronizer chain all ones.
- Synchronizer: SYNC_STAGES flops, async-set by rst, shifting in 0. rst_sync is the last stage.
- FSM states:
  - SYNC: wait for rst_sync low, then go to HOLD with counter 0.
  - HOLD: count HOLD_CYCLES edges. On the final count, clear domain_rst_o[0] and go to WAIT with cur=0.
  - WAIT(cur): sample domain_ready_i[cur] starting the edge after release; ready values before that edge are ignored. If ready is seen, or the counter reaches TIMEOUT_CYCLES (then set err_o[cur]):
    - if cur is the last domain, go to DONE and set done_o the same edge;
    - else if GAP_CYCLES=0, go straight to the release of cur+1;
    - otherwise go to GAP.
  - GAP: count GAP_CYCLES, then clear domain_rst_o[cur+1], cur++, go to WAIT.
  - DONE: hold outputs.
- sw_reset_req is sampled in every state except SYNC. When high at an edge: domain_rst_o all ones, done_o 0, err_o 0, cur 0, counter 0, state HOLD. It has priority over every other transition at that edge, including timeout and ready. While it is held high, HOLD restarts every cycle.
- Released domains never re-enter reset except via rst or sw_reset_req.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.

## Timing
- Edge numbering: edge 1 is the first rising clk edge with rst low.
- rst_sync falls at edge SYNC_STAGES.
- domain_rst_o[0] falls at edge SYNC_STAGES+HOLD_CYCLES.
- Release at edge r, ready sampled high at edge r+k (k>=1):
  - next domain falls at edge r+k+GAP_CYCLES+1;
  - for the last domain, done_o rises at edge r+k.
- Timeout with release at edge r: err_o[cur] is set at edge r+TIMEOUT_CYCLES, treated as ready at that edge.
- sw_reset_req high at edge s: outputs change at edge s. If the request is low from edge s+1, domain 0 falls at edge s+HOLD_CYCLES.
- rst assertion mid-sequence: outputs reset asynchronously in the same timestep, and the full sequence restarts after deassertion.

## Test plan
- N=4, SYNC=2, HOLD=8, GAP=2, TIMEOUT=16, ready tied high. Release rst before edge 1 -> domain_rst_o falls 1110 @10, 1100 @14, 1000 @18, 0000 @22; done_o=1 @23; err_o=0.
- Same, but domain_ready_i[1] stuck low -> domain1 released @14, err_o=0010 @30, domain2 released @33, done_o set, err_o held at 0010.
- Assert rst asynchronously between edges 15 and 16 -> domain_rst_o=1111, done_o=0, err_o=0 with no clock edge. Deassert -> sequence repeats with the exact edge timing of test 1.
- After done, pulse sw_reset_req at edge s -> 1111 and err_o=0 at s, domain0 falls at s+8. Holding the request 5 cycles delays domain0 release to s+4+8.
- sw_reset_req and domain1 timeout on the same edge -> err_o[1] stays 0, all domains are reset, state is HOLD.
- domain_ready_i[0] high before release, then dropped at the release edge and raised 3 cycles later -> domain1 release is keyed off the later ready (edge r+3+GAP+1).
